// File: rtl/up_arbiter.sv
// Two-channel (write/read) round-robin arbiter sharing one UP_WR/UP_RD slave port.
// Optional slave-ack watchdog enabled by defining UP_ARB_TIMEOUT_EN.
module up_arbiter #(
    parameter int C_NUM_MASTERS = 2,
    parameter int C_ADDR_WIDTH  = 10,
    parameter int C_DATA_WIDTH  = 32,
    parameter int C_TIMEOUT     = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [C_NUM_MASTERS*C_ADDR_WIDTH-1:0] s_wr_addr,
    input  logic [C_NUM_MASTERS*C_DATA_WIDTH/8-1:0] s_wr_be,
    input  logic [C_NUM_MASTERS*C_DATA_WIDTH-1:0] s_wr_din,
    input  logic [C_NUM_MASTERS-1:0]              s_wr_req,
    output logic [C_NUM_MASTERS-1:0]              s_wr_ack,
    input  logic [C_NUM_MASTERS*C_ADDR_WIDTH-1:0] s_rd_addr,
    input  logic [C_NUM_MASTERS-1:0]              s_rd_req,
    output logic [C_DATA_WIDTH-1:0]               s_rd_dout,
    output logic [C_NUM_MASTERS-1:0]              s_rd_ack,
    output logic [C_ADDR_WIDTH-1:0]               m_wr_addr,
    output logic [C_DATA_WIDTH/8-1:0]             m_wr_be,
    output logic [C_DATA_WIDTH-1:0]               m_wr_din,
    output logic                                  m_wr_req,
    input  logic                                  m_wr_ack,
    output logic [C_ADDR_WIDTH-1:0]               m_rd_addr,
    output logic                                  m_rd_req,
    input  logic [C_DATA_WIDTH-1:0]               m_rd_dout,
    input  logic                                  m_rd_ack,
    output logic [1:0]                            timeout
);

    localparam int N  = C_NUM_MASTERS;
    localparam int AW = C_ADDR_WIDTH;
    localparam int DW = C_DATA_WIDTH;
    localparam int BW = C_DATA_WIDTH / 8;
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Highest priority goes to last+1; scanning from the far end lets the nearest active win.
    function automatic logic [GW-1:0] rr_pick(input logic [N-1:0] active, input logic [GW-1:0] last);
        int idx;
        rr_pick = last;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= N) idx -= N;
            if (active[idx]) rr_pick = GW'(idx);
        end
    endfunction

    // C_TIMEOUT is consumed only by the watchdog build; this keeps it referenced in both.
    if (C_TIMEOUT < 1) begin : g_timeout_must_be_positive
    end

    state_t          wr_state, rd_state;
    logic [N-1:0]    wr_pending, rd_pending;
    logic [N-1:0]    wr_active, rd_active;
    logic [GW-1:0]   wr_last, rd_last;
    logic [GW-1:0]   wr_gnt, rd_gnt;
    logic [GW-1:0]   wr_win, rd_win;
    logic            wr_expire, rd_expire;
    logic            wr_done, rd_done;

    assign wr_active = wr_pending | s_wr_req;
    assign rd_active = rd_pending | s_rd_req;
    assign wr_win    = rr_pick(wr_active, wr_last);
    assign rd_win    = rr_pick(rd_active, rd_last);

`ifdef UP_ARB_TIMEOUT_EN
    localparam int CW = $clog2(C_TIMEOUT + 1);

    logic [CW-1:0] wr_cnt, rd_cnt;

    // A real slave ack wins over expiry landing in the same cycle.
    assign wr_expire = (wr_state == BUSY) && !m_wr_ack && (wr_cnt == CW'(C_TIMEOUT - 1));
    assign rd_expire = (rd_state == BUSY) && !m_rd_ack && (rd_cnt == CW'(C_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            timeout <= 2'b00;
        end else begin
            wr_cnt  <= (wr_state == BUSY) ? wr_cnt + 1'b1 : '0;
            rd_cnt  <= (rd_state == BUSY) ? rd_cnt + 1'b1 : '0;
            timeout <= {rd_expire, wr_expire};
        end
    end
`else
    assign wr_expire = 1'b0;
    assign rd_expire = 1'b0;
    assign timeout   = 2'b00;
`endif

    assign wr_done = (wr_state == BUSY) && (m_wr_ack || wr_expire);
    assign rd_done = (rd_state == BUSY) && (m_rd_ack || rd_expire);

    // Write channel
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state   <= IDLE;
            wr_pending <= '0;
            wr_last    <= GW'(N - 1);
            wr_gnt     <= '0;
            m_wr_req   <= 1'b0;
            m_wr_addr  <= '0;
            m_wr_be    <= '0;
            m_wr_din   <= '0;
            s_wr_ack   <= '0;
        end else begin
            // NOTE: state uses non-blocking assignments; later writes to the same bit
            // in this block override earlier ones, which the pending clear relies on.
            m_wr_req   <= 1'b0;
            s_wr_ack   <= '0;
            wr_pending <= wr_active;
            case (wr_state)
                IDLE: begin
                    if (|wr_active) begin
                        wr_state  <= BUSY;
                        wr_gnt    <= wr_win;
                        wr_last   <= wr_win;
                        m_wr_req  <= 1'b1;
                        m_wr_addr <= s_wr_addr[int'(wr_win)*AW +: AW];
                        m_wr_be   <= s_wr_be[int'(wr_win)*BW +: BW];
                        m_wr_din  <= s_wr_din[int'(wr_win)*DW +: DW];
                    end
                end
                BUSY: begin
                    if (wr_done) begin
                        wr_state           <= IDLE;
                        s_wr_ack[wr_gnt]   <= 1'b1;
                        wr_pending[wr_gnt] <= 1'b0;
                    end
                end
                default: wr_state <= IDLE;
            endcase
        end
    end

    // Read channel; identical except for the returned data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state   <= IDLE;
            rd_pending <= '0;
            rd_last    <= GW'(N - 1);
            rd_gnt     <= '0;
            m_rd_req   <= 1'b0;
            m_rd_addr  <= '0;
            s_rd_ack   <= '0;
            s_rd_dout  <= '0;
        end else begin
            m_rd_req   <= 1'b0;
            s_rd_ack   <= '0;
            rd_pending <= rd_active;
            case (rd_state)
                IDLE: begin
                    if (|rd_active) begin
                        rd_state  <= BUSY;
                        rd_gnt    <= rd_win;
                        rd_last   <= rd_win;
                        m_rd_req  <= 1'b1;
                        m_rd_addr <= s_rd_addr[int'(rd_win)*AW +: AW];
                    end
                end
                BUSY: begin
                    if (rd_done) begin
                        rd_state           <= IDLE;
                        s_rd_ack[rd_gnt]   <= 1'b1;
                        rd_pending[rd_gnt] <= 1'b0;
                        s_rd_dout          <= rd_expire ? '0 : m_rd_dout;
                    end
                end
                default: rd_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_up_arbiter.sv
// Directed self-checking bench for up_arbiter (2 requesters, C_TIMEOUT = 4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_up_arbiter;

    localparam int N  = 2;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*AW-1:0]   s_wr_addr;
    logic [N*BW-1:0]   s_wr_be;
    logic [N*DW-1:0]   s_wr_din;
    logic [N-1:0]      s_wr_req;
    logic [N-1:0]      s_wr_ack;
    logic [N*AW-1:0]   s_rd_addr;
    logic [N-1:0]      s_rd_req;
    logic [DW-1:0]     s_rd_dout;
    logic [N-1:0]      s_rd_ack;
    logic [AW-1:0]     m_wr_addr;
    logic [BW-1:0]     m_wr_be;
    logic [DW-1:0]     m_wr_din;
    logic              m_wr_req;
    logic              m_wr_ack;
    logic [AW-1:0]     m_rd_addr;
    logic              m_rd_req;
    logic [DW-1:0]     m_rd_dout;
    logic              m_rd_ack;
    logic [1:0]        timeout;

    int total = 0;
    int bad   = 0;

    up_arbiter #(
        .C_NUM_MASTERS(N),
        .C_ADDR_WIDTH (AW),
        .C_DATA_WIDTH (DW),
        .C_TIMEOUT    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_wr_addr (s_wr_addr),
        .s_wr_be   (s_wr_be),
        .s_wr_din  (s_wr_din),
        .s_wr_req  (s_wr_req),
        .s_wr_ack  (s_wr_ack),
        .s_rd_addr (s_rd_addr),
        .s_rd_req  (s_rd_req),
        .s_rd_dout (s_rd_dout),
        .s_rd_ack  (s_rd_ack),
        .m_wr_addr (m_wr_addr),
        .m_wr_be   (m_wr_be),
        .m_wr_din  (m_wr_din),
        .m_wr_req  (m_wr_req),
        .m_wr_ack  (m_wr_ack),
        .m_rd_addr (m_rd_addr),
        .m_rd_req  (m_rd_req),
        .m_rd_dout (m_rd_dout),
        .m_rd_ack  (m_rd_ack),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        s_wr_addr = '0; s_wr_be = '0; s_wr_din = '0; s_wr_req = '0;
        s_rd_addr = '0; s_rd_req = '0;
        m_wr_ack = 1'b0; m_rd_ack = 1'b0; m_rd_dout = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        s_wr_req = 2'b11; s_rd_req = 2'b11; m_rd_dout = 32'hFFFF_FFFF;
        tick(); tick();
        total++; if (s_wr_ack !== 2'b00) begin bad++; $display("FAIL reset_s_wr_ack: got %b want 00", s_wr_ack); end
        total++; if (s_rd_ack !== 2'b00) begin bad++; $display("FAIL reset_s_rd_ack: got %b want 00", s_rd_ack); end
        total++; if (m_wr_req !== 1'b0) begin bad++; $display("FAIL reset_m_wr_req: got %b want 0", m_wr_req); end
        total++; if (m_rd_req !== 1'b0) begin bad++; $display("FAIL reset_m_rd_req: got %b want 0", m_rd_req); end
        total++; if (timeout !== 2'b00) begin bad++; $display("FAIL reset_timeout: got %b want 00", timeout); end
        total++; if ({m_wr_addr, m_wr_be, m_wr_din} !== '0) begin bad++; $display("FAIL reset_m_wr_cmd: got %h/%h/%h want 0", m_wr_addr, m_wr_be, m_wr_din); end
        total++; if (m_rd_addr !== '0) begin bad++; $display("FAIL reset_m_rd_addr: got %h want 0", m_rd_addr); end
        total++; if (s_rd_dout !== '0) begin bad++; $display("FAIL reset_s_rd_dout: got %h want 0", s_rd_dout); end
        clear_inputs();
        rst = 1'b0;
        tick();
        total++; if ({m_wr_req, m_rd_req} !== 2'b00) begin bad++; $display("FAIL reset_reqs_dropped: got %b want 00", {m_wr_req, m_rd_req}); end
    endtask

    task automatic test_single_write();
        do_reset();
        s_wr_addr[0 +: AW] = 10'h010; s_wr_be[0 +: BW] = 4'hF; s_wr_din[0 +: DW] = 32'hA5A5_0001;
        s_wr_req = 2'b01;
        tick();
        s_wr_req = 2'b00;
        total++; if (m_wr_req !== 1'b1) begin bad++; $display("FAIL wr_m_req: got %b want 1", m_wr_req); end
        total++; if (m_wr_addr !== 10'h010) begin bad++; $display("FAIL wr_addr: got %h want 010", m_wr_addr); end
        total++; if (m_wr_be !== 4'hF) begin bad++; $display("FAIL wr_be: got %h want f", m_wr_be); end
        total++; if (m_wr_din !== 32'hA5A5_0001) begin bad++; $display("FAIL wr_din: got %h want a5a50001", m_wr_din); end
        total++; if (m_rd_req !== 1'b0) begin bad++; $display("FAIL wr_no_rd_req: got %b want 0", m_rd_req); end
        tick();
        total++; if (m_wr_req !== 1'b0) begin bad++; $display("FAIL wr_m_req_one_cycle: got %b want 0", m_wr_req); end
        total++; if (s_wr_ack !== 2'b00) begin bad++; $display("FAIL wr_ack_early: got %b want 00", s_wr_ack); end
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        total++; if (s_wr_ack !== 2'b01) begin bad++; $display("FAIL wr_ack: got %b want 01", s_wr_ack); end
        tick();
        total++; if (s_wr_ack !== 2'b00) begin bad++; $display("FAIL wr_ack_pulse: got %b want 00", s_wr_ack); end
        total++; if (m_wr_req !== 1'b0) begin bad++; $display("FAIL wr_no_reissue: got %b want 0", m_wr_req); end
    endtask

    task automatic test_simultaneous_reads();
        do_reset();
        s_rd_addr[0 +: AW] = 10'h100; s_rd_addr[AW +: AW] = 10'h200;
        s_rd_req = 2'b11;
        tick();
        s_rd_req = 2'b00;
        total++; if ({m_rd_req, m_rd_addr} !== {1'b1, 10'h100}) begin bad++; $display("FAIL rd_first_grant: got %b/%h want 1/100", m_rd_req, m_rd_addr); end
        tick();
        m_rd_ack = 1'b1; m_rd_dout = 32'h11;
        tick();
        m_rd_ack = 1'b0; m_rd_dout = 32'hDEAD;
        total++; if (s_rd_ack !== 2'b01) begin bad++; $display("FAIL rd_ack0: got %b want 01", s_rd_ack); end
        total++; if (s_rd_dout !== 32'h11) begin bad++; $display("FAIL rd_dout0: got %h want 11", s_rd_dout); end
        tick();
        total++; if ({m_rd_req, m_rd_addr} !== {1'b1, 10'h200}) begin bad++; $display("FAIL rd_second_grant: got %b/%h want 1/200", m_rd_req, m_rd_addr); end
        total++; if (s_rd_ack !== 2'b00) begin bad++; $display("FAIL rd_ack_pulse: got %b want 00", s_rd_ack); end
        tick();
        m_rd_ack = 1'b1; m_rd_dout = 32'h22;
        tick();
        m_rd_ack = 1'b0;
        total++; if (s_rd_ack !== 2'b10) begin bad++; $display("FAIL rd_ack1: got %b want 10", s_rd_ack); end
        total++; if (s_rd_dout !== 32'h22) begin bad++; $display("FAIL rd_dout1: got %h want 22", s_rd_dout); end
    endtask

    task automatic test_concurrent_channels();
        do_reset();
        s_wr_addr[AW +: AW] = 10'h3C3; s_wr_be[BW +: BW] = 4'h5; s_wr_din[DW +: DW] = 32'h1234_5678;
        s_rd_addr[0 +: AW] = 10'h0F0;
        s_wr_req = 2'b10; s_rd_req = 2'b01;
        tick();
        s_wr_req = 2'b00; s_rd_req = 2'b00;
        total++; if ({m_wr_req, m_rd_req} !== 2'b11) begin bad++; $display("FAIL conc_both_req: got %b want 11", {m_wr_req, m_rd_req}); end
        total++; if ({m_wr_addr, m_wr_be, m_wr_din} !== {10'h3C3, 4'h5, 32'h1234_5678}) begin bad++; $display("FAIL conc_wr_cmd: got %h/%h/%h want 3c3/5/12345678", m_wr_addr, m_wr_be, m_wr_din); end
        total++; if (m_rd_addr !== 10'h0F0) begin bad++; $display("FAIL conc_rd_addr: got %h want 0f0", m_rd_addr); end
        tick();
        m_wr_ack = 1'b1; m_rd_ack = 1'b1; m_rd_dout = 32'h33;
        tick();
        m_wr_ack = 1'b0; m_rd_ack = 1'b0;
        total++; if ({s_wr_ack, s_rd_ack} !== 4'b1001) begin bad++; $display("FAIL conc_acks: got wr=%b rd=%b want wr=10 rd=01", s_wr_ack, s_rd_ack); end
        total++; if (s_rd_dout !== 32'h33) begin bad++; $display("FAIL conc_rd_dout: got %h want 33", s_rd_dout); end
    endtask

    task automatic test_round_robin();
        logic [AW-1:0] exp_addr;
        logic [N-1:0]  exp_ack;
        do_reset();
        s_wr_addr[0 +: AW] = 10'h0A0; s_wr_addr[AW +: AW] = 10'h0B0;
        s_wr_req = 2'b11;
        for (int k = 0; k < 8; k++) begin
            exp_addr = (k % 2 == 0) ? 10'h0A0 : 10'h0B0;
            exp_ack  = (k % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            s_wr_req = 2'b00;
            total++; if ({m_wr_req, m_wr_addr} !== {1'b1, exp_addr}) begin bad++; $display("FAIL rr_grant_%0d: got %b/%h want 1/%h", k, m_wr_req, m_wr_addr, exp_addr); end
            tick();
            m_wr_ack = 1'b1;
            tick();
            m_wr_ack = 1'b0;
            total++; if (s_wr_ack !== exp_ack) begin bad++; $display("FAIL rr_ack_%0d: got %b want %b", k, s_wr_ack, exp_ack); end
            s_wr_req = exp_ack;
        end
        s_wr_req = 2'b00;
        tick();
        tick();
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        s_rd_addr[0 +: AW] = 10'h155;
        s_rd_req = 2'b01;
        tick();
        s_rd_req = 2'b00;
        total++; if (m_rd_req !== 1'b1) begin bad++; $display("FAIL midrst_m_req: got %b want 1", m_rd_req); end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if ({s_rd_ack, m_rd_req, m_rd_addr, s_rd_dout, timeout} !== '0) begin bad++; $display("FAIL midrst_outputs: ack=%b req=%b addr=%h dout=%h to=%b want all 0", s_rd_ack, m_rd_req, m_rd_addr, s_rd_dout, timeout); end
        m_rd_ack = 1'b1; m_rd_dout = 32'hBAD0;
        tick();
        m_rd_ack = 1'b0;
        tick();
        total++; if ({s_rd_ack, m_rd_req} !== 3'b000) begin bad++; $display("FAIL midrst_dropped: got ack=%b req=%b want 00/0", s_rd_ack, m_rd_req); end
        s_rd_addr[AW +: AW] = 10'h2AA;
        s_rd_req = 2'b10;
        tick();
        s_rd_req = 2'b00;
        total++; if ({m_rd_req, m_rd_addr} !== {1'b1, 10'h2AA}) begin bad++; $display("FAIL midrst_fresh_req: got %b/%h want 1/2aa", m_rd_req, m_rd_addr); end
        tick();
        m_rd_ack = 1'b1; m_rd_dout = 32'h44;
        tick();
        m_rd_ack = 1'b0;
        total++; if ({s_rd_ack, s_rd_dout} !== {2'b10, 32'h44}) begin bad++; $display("FAIL midrst_fresh_ack: got %b/%h want 10/44", s_rd_ack, s_rd_dout); end
    endtask

`ifdef UP_ARB_TIMEOUT_EN
    task automatic test_timeout();
        s_rd_addr[AW +: AW] = 10'h321;
        s_rd_req = 2'b10;
        tick();
        s_rd_req = 2'b00;
        total++; if (m_rd_req !== 1'b1) begin bad++; $display("FAIL to_m_req: got %b want 1", m_rd_req); end
        tick(); tick(); tick();
        total++; if ({s_rd_ack, timeout} !== 4'b0000) begin bad++; $display("FAIL to_early: ack=%b to=%b want 00/00", s_rd_ack, timeout); end
        tick();
        total++; if ({s_rd_ack, timeout} !== 4'b1010) begin bad++; $display("FAIL to_pulse: ack=%b to=%b want 10/10", s_rd_ack, timeout); end
        total++; if (s_rd_dout !== 32'h0) begin bad++; $display("FAIL to_dout: got %h want 0", s_rd_dout); end
        m_rd_ack = 1'b1; m_rd_dout = 32'h77;
        tick();
        m_rd_ack = 1'b0;
        total++; if (timeout !== 2'b00) begin bad++; $display("FAIL to_one_cycle: got %b want 00", timeout); end
        tick();
        total++; if (s_rd_ack !== 2'b00) begin bad++; $display("FAIL to_late_ack: got %b want 00", s_rd_ack); end
        s_wr_addr[0 +: AW] = 10'h3FF; s_wr_be[0 +: BW] = 4'h3; s_wr_din[0 +: DW] = 32'hDEAD_BEEF;
        s_wr_req = 2'b01;
        tick();
        s_wr_req = 2'b00;
        total++; if ({m_wr_req, m_wr_addr, m_wr_be, m_wr_din} !== {1'b1, 10'h3FF, 4'h3, 32'hDEAD_BEEF}) begin bad++; $display("FAIL to_wr_cmd: got %b/%h/%h/%h", m_wr_req, m_wr_addr, m_wr_be, m_wr_din); end
        tick();
        m_wr_ack = 1'b1;
        tick();
        m_wr_ack = 1'b0;
        total++; if ({s_wr_ack, timeout} !== 4'b0100) begin bad++; $display("FAIL to_wr_ack: ack=%b to=%b want 01/00", s_wr_ack, timeout); end
    endtask
`else
    task automatic test_timeout();
        s_rd_addr[AW +: AW] = 10'h321;
        s_rd_req = 2'b10;
        tick();
        s_rd_req = 2'b00;
        total++; if (m_rd_req !== 1'b1) begin bad++; $display("FAIL wait_m_req: got %b want 1", m_rd_req); end
        for (int k = 0; k < 8; k++) begin
            tick();
            total++; if ({s_rd_ack, timeout, m_rd_req} !== 5'b00000) begin bad++; $display("FAIL wait_forever_%0d: ack=%b to=%b req=%b want 0", k, s_rd_ack, timeout, m_rd_req); end
        end
        m_rd_ack = 1'b1; m_rd_dout = 32'h55;
        tick();
        m_rd_ack = 1'b0;
        total++; if ({s_rd_ack, s_rd_dout, timeout} !== {2'b10, 32'h55, 2'b00}) begin bad++; $display("FAIL wait_ack: got %b/%h/%b want 10/55/00", s_rd_ack, s_rd_dout, timeout); end
    endtask
`endif

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        test_reset();
        test_single_write();
        test_simultaneous_reads();
        test_concurrent_channels();
        test_round_robin();
        test_reset_mid_op();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
